// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : serial_add_ctrl
//  Brief    : Bit-serial adder/subtractor, one 1-bit full-adder cell, LSB first.
//  Revision : 1.0  initial release
// ============================================================================

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  if (WIDTH < 2 || WIDTH > 32) begin : g_width_check
    $error("serial_add_ctrl: WIDTH must be in 2..32");
  end

  localparam int             CW     = $clog2(WIDTH);
  localparam logic [CW-1:0]  C_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-2:0] res_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  // The single full-adder cell shared by every bit position.
  logic             w_fa_s;
  logic             w_fa_c;
  logic [WIDTH-1:0] w_res_cat;

  assign w_fa_s    = a_q[0] ^ b_q[0] ^ carry_q;
  assign w_fa_c    = (a_q[0] & b_q[0]) | ((a_q[0] ^ b_q[0]) & carry_q);
  assign w_res_cat = {w_fa_s, res_q};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= sub ? 1'b1 : cin;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          res_q   <= w_res_cat[WIDTH-1:1];
          carry_q <= w_fa_c;
          cnt_q   <= cnt_q + CW'(1);
          // carry_q still holds the carry into the MSB on the last bit.
          if (cnt_q == C_LAST) begin
            sum_q   <= w_res_cat;
            cout_q  <= w_fa_c;
            ovf_q   <= w_fa_c ^ carry_q;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_add_ctrl
//  Brief    : Scoreboard bench for serial_add_ctrl against an arithmetic model.
//  Revision : 1.0  initial release
// ============================================================================

module tb_serial_add_ctrl;

  localparam int W   = 8;
  localparam int MOD = 1 << W;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic         cin;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         v;
  } exp_t;

  exp_t q[$];
  exp_t last_res;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: unsigned sum for result/carry, signed sum range test for overflow.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic ci, input logic s);
    int   ux, uy, sx, sy, full, r;
    exp_t e;
    ux = int'(x);
    uy = int'(y);
    sx = (ux >= MOD / 2) ? ux - MOD : ux;
    sy = (uy >= MOD / 2) ? uy - MOD : uy;
    if (s) begin
      full = ux + (MOD - 1 - uy) + 1;
      r    = sx - sy;
    end else begin
      full = ux + uy + int'(ci);
      r    = sx + sy + int'(ci);
    end
    e.s = W'(full % MOD);
    e.c = (full >= MOD);
    e.v = (r > MOD / 2 - 1) || (r < -(MOD / 2));
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: got done=1 sum=0x%0h, expected no done", sum);
        end else begin
          e = q.pop_front();
          chk("sum", 32'(sum), 32'(e.s));
          chk("cout", 32'(cout), 32'(e.c));
          chk("ovf", 32'(ovf), 32'(e.v));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  // One operation; poke>=0 re-asserts start with other operands during RUN.
  task automatic op(input logic [W-1:0] xa, input logic [W-1:0] xb,
                    input logic xc, input logic xs, input int poke);
    exp_t e;
    e = model(xa, xb, xc, xs);
    @(negedge clk);
    a = xa; b = xb; cin = xc; sub = xs; start = 1'b1;
    q.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); sub = 1'($urandom); cin = 1'($urandom);
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      chk("busy_run", 32'(busy), 32'd1);
      chk("done_run", 32'(done), 32'd0);
      chk("sum_hold", 32'(sum), 32'(last_res.s));
      if (i == poke) begin
        a = W'($urandom); b = W'($urandom); start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    @(negedge clk);
    start = 1'b0;
    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_done", 32'(busy), 32'd0);
    last_res = e;
    @(negedge clk);
    chk("done_clear", 32'(done), 32'd0);
    chk("sum_keep", 32'(sum), 32'(last_res.s));
  endtask

  initial begin
    int   ndone;
    int   stamps[3];
    exp_t e;

    rst_n = 1'b0; start = 1'b1; sub = 1'b0; cin = 1'b1; a = 8'hAA; b = 8'h55;
    last_res = '{s: '0, c: 1'b0, v: 1'b0};
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1; start = 1'b0;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);

    // Directed corner cases, expectations written out by hand.
    op(8'h0F, 8'h01, 1'b0, 1'b0, -1);
    chk("dir1_sum", 32'(last_res.s), 32'h10);
    chk("dir1_cv", 32'({last_res.c, last_res.v}), 32'h0);
    op(8'hFF, 8'h01, 1'b1, 1'b0, -1);
    chk("dir2_sum", 32'(last_res.s), 32'h01);
    chk("dir2_cv", 32'({last_res.c, last_res.v}), 32'h2);
    op(8'h7F, 8'h01, 1'b0, 1'b0, -1);
    chk("dir3_sum", 32'(last_res.s), 32'h80);
    chk("dir3_cv", 32'({last_res.c, last_res.v}), 32'h1);
    op(8'h05, 8'h07, 1'b1, 1'b1, -1);
    chk("dir4_sum", 32'(last_res.s), 32'hFE);
    chk("dir4_cv", 32'({last_res.c, last_res.v}), 32'h0);
    op(8'h10, 8'h20, 1'b0, 1'b0, 2);
    chk("dir5_sum", 32'(last_res.s), 32'h30);

    // Abort mid-run with reset; no done may follow.
    @(negedge clk);
    a = 8'h33; b = 8'h44; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0; start = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_sum", 32'(sum), 32'd0);
    chk("abort_cout", 32'(cout), 32'd0);
    chk("abort_ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1; start = 1'b0;
    last_res = '{s: '0, c: 1'b0, v: 1'b0};
    repeat (W + 3) begin
      @(negedge clk);
      chk("abort_nodone", 32'(done), 32'd0);
    end
    op(8'h03, 8'h04, 1'b0, 1'b0, -1);
    chk("post_abort_sum", 32'(last_res.s), 32'h07);

    // Back-to-back with start held: one operation every W+2 cycles.
    @(negedge clk);
    a = 8'hC3; b = 8'h5A; sub = 1'b1; cin = 1'b0; start = 1'b1;
    e = model(8'hC3, 8'h5A, 1'b0, 1'b1);
    repeat (3) q.push_back(e);
    ndone = 0;
    for (int cyc = 0; cyc < 6 * (W + 2); cyc++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        stamps[ndone] = cyc;
        ndone++;
        if (ndone == 3) begin
          start = 1'b0;
          break;
        end
      end
    end
    chk("b2b_count", 32'(ndone), 32'd3);
    if (ndone == 3) begin
      chk("b2b_gap1", 32'(stamps[1] - stamps[0]), 32'(W + 2));
      chk("b2b_gap2", 32'(stamps[2] - stamps[1]), 32'(W + 2));
    end
    last_res = e;
    repeat (2) @(negedge clk);
    chk("b2b_idle", 32'(busy), 32'd0);

    // Randomized operations, some with a stray start pulse during RUN.
    for (int n = 0; n < 40; n++) begin
      int poke;
      poke = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, W - 1)) : -1;
      op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), poke);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    for (int t = 0; t < 20 && q.size() != 0; t++) @(negedge clk);
    chk("queue_drain", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
